// File: rtl/vline_pkg.sv
`default_nettype none
// ============================================================================
// Package   : vline_pkg
// Purpose   : Shared types and default sizes for the video line buffer.
// Revision  : 1.0 - initial release
// ============================================================================
package vline_pkg;

    localparam int c_DATA_W     = 16;
    localparam int c_WORDS      = 128;
    localparam int c_LINES      = 256;
    localparam int c_LINE_END_W = 4;

    typedef enum logic [2:0] {
        F_IDLE = 3'd0,
        F_REQ  = 3'd1,
        F_WAIT = 3'd2,
        F_FILL = 3'd3,
        F_DONE = 3'd4
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/video_line_buf_if.sv
`default_nettype none
// ============================================================================
// Interface : video_line_buf_if
// Purpose   : SDRAM video port, timing pulses and serializer read port.
// Revision  : 1.0 - initial release
// ============================================================================
interface video_line_buf_if
    import vline_pkg::*;
#(
    parameter int DATA_W = c_DATA_W
) ();
    logic [DATA_W-1:0] i_vdata;
    logic              i_vdata_valid;
    logic              i_vdata_reset;
    logic [7:0]        o_line_idx;
    logic              o_line_end;
    logic              i_frame_start;
    logic              i_line_start;
    logic              i_rd_en;
    logic [DATA_W-1:0] o_rd_data;
    logic              o_rd_valid;
    logic              o_underrun;

    modport slave (
        input  i_vdata, i_vdata_valid, i_vdata_reset,
        input  i_frame_start, i_line_start, i_rd_en,
        output o_line_idx, o_line_end, o_rd_data, o_rd_valid, o_underrun
    );

    modport master (
        output i_vdata, i_vdata_valid, i_vdata_reset,
        output i_frame_start, i_line_start, i_rd_en,
        input  o_line_idx, o_line_end, o_rd_data, o_rd_valid, o_underrun
    );
endinterface
`default_nettype wire

// File: rtl/vline_ram.sv
`default_nettype none
// ============================================================================
// Module    : vline_ram
// Purpose   : Simple dual-port RAM, registered read; address MSB = bank.
// Revision  : 1.0 - initial release
// ============================================================================
module vline_ram #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we)
            r_mem[i_waddr] <= i_wdata;
        if (i_re)
            r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;
endmodule
`default_nettype wire

// File: rtl/video_line_buf.sv
`default_nettype none
// ============================================================================
// Module    : video_line_buf
// Purpose   : Ping-pong scanline buffer between SDRAM video port and serializer.
//             Define VIDEO_LINE_BUF_DOUBLE_SCAN_EN to show each line twice.
// Revision  : 1.0 - initial release
// ============================================================================
module video_line_buf
    import vline_pkg::*;
#(
    parameter int DATA_W     = c_DATA_W,
    parameter int WORDS      = c_WORDS,
    parameter int LINES      = c_LINES,
    parameter int LINE_END_W = c_LINE_END_W
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    video_line_buf_if.slave bus
);
    localparam int c_IDX_W = $clog2(WORDS);
    localparam int c_PTR_W = c_IDX_W + 1;
    localparam int c_CNT_W = $clog2(LINES) + 1;
    localparam int c_LE_W  = $clog2(LINE_END_W + 1);

    fetch_state_t        r_state;
    fetch_state_t        w_state_nxt;
    logic [c_LE_W-1:0]   r_le_cnt;
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_line_cnt;
    logic [c_CNT_W-1:0]  w_line_inc;
    logic                r_bank;
    logic [7:0]          r_line_idx;
    logic                r_line_end;
    logic                r_underrun;
    logic                r_rd_valid;
    logic                r_rd_zero;
    logic [DATA_W-1:0]   w_ram_q;

    logic w_frame, w_line, w_primary, w_done, w_swap, w_more, w_trig;
    logic w_we, w_rd_hit;

`ifdef VIDEO_LINE_BUF_DOUBLE_SCAN_EN
    logic r_phase;
    // Only the first line start of each pair swaps and fetches.
    assign w_primary = w_line & ~r_phase;
`else
    assign w_primary = w_line;
`endif

    assign w_frame    = bus.i_frame_start;
    assign w_line     = bus.i_line_start & ~bus.i_frame_start;
    assign w_done     = (r_state == F_DONE);
    assign w_line_inc = r_line_cnt + c_CNT_W'(1);
    assign w_more     = (w_line_inc < c_CNT_W'(LINES));
    assign w_swap     = w_primary & w_done;
    assign w_trig     = w_frame | (w_swap & w_more);

    assign w_we     = (r_state == F_FILL) & ~bus.i_vdata_reset & bus.i_vdata_valid
                    & (r_wr_ptr != c_PTR_W'(WORDS));
    assign w_rd_hit = bus.i_rd_en & (r_rd_ptr != c_PTR_W'(WORDS));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            F_REQ:   if (r_le_cnt == c_LE_W'(LINE_END_W - 1)) w_state_nxt = F_WAIT;
            F_WAIT:  if (bus.i_vdata_reset)                    w_state_nxt = F_FILL;
            F_FILL:  if (r_wr_ptr == c_PTR_W'(WORDS))          w_state_nxt = F_DONE;
            default: ;
        endcase
        if (w_swap)
            w_state_nxt = w_more ? F_REQ : F_IDLE;
        if (w_frame)
            w_state_nxt = F_REQ;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state    <= F_IDLE;
            r_le_cnt   <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_line_cnt <= '0;
            r_bank     <= 1'b0;
            r_line_idx <= '0;
            r_line_end <= 1'b0;
            r_underrun <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_zero  <= 1'b0;
`ifdef VIDEO_LINE_BUF_DOUBLE_SCAN_EN
            r_phase    <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_le_cnt   <= (w_trig || r_state != F_REQ) ? '0 : r_le_cnt + c_LE_W'(1);
            r_line_end <= (w_state_nxt == F_REQ);
            if (w_trig)
                r_line_idx <= w_frame ? 8'd0 : 8'(w_line_inc);

            if (bus.i_vdata_reset || w_trig)
                r_wr_ptr <= '0;
            else if (w_we)
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);

            // Every accepted line start re-arms the reader, swapped or not.
            if (w_line)
                r_rd_ptr <= '0;
            else if (w_rd_hit)
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);

            if (w_swap)
                r_bank <= ~r_bank;

            if (w_frame)
                r_line_cnt <= '0;
            else if (w_primary)
                r_line_cnt <= w_line_inc;

            if (w_frame)
                r_underrun <= 1'b0;
            else if (w_primary && !w_done)
                r_underrun <= 1'b1;

`ifdef VIDEO_LINE_BUF_DOUBLE_SCAN_EN
            if (w_frame)
                r_phase <= 1'b0;
            else if (w_line)
                r_phase <= ~r_phase;
`endif
            r_rd_valid <= bus.i_rd_en;
            r_rd_zero  <= ~w_rd_hit;
        end
    end

    // r_bank selects the display half; the fill half is its complement.
    vline_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (2 * WORDS),
        .ADDR_W (c_PTR_W)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (w_we),
        .i_waddr ({~r_bank, r_wr_ptr[c_IDX_W-1:0]}),
        .i_wdata (bus.i_vdata),
        .i_re    (w_rd_hit),
        .i_raddr ({r_bank, r_rd_ptr[c_IDX_W-1:0]}),
        .o_rdata (w_ram_q)
    );

    assign bus.o_line_idx = r_line_idx;
    assign bus.o_line_end = r_line_end;
    assign bus.o_rd_data  = (r_rd_valid && !r_rd_zero) ? w_ram_q : '0;
    assign bus.o_rd_valid = r_rd_valid;
    assign bus.o_underrun = r_underrun;
endmodule
`default_nettype wire

// File: tb/tb_video_line_buf.sv
`default_nettype none
// ============================================================================
// Module    : tb_video_line_buf
// Purpose   : Directed self-checking bench for video_line_buf.
// Revision  : 1.0 - initial release
// ============================================================================
module tb_video_line_buf;
    import vline_pkg::*;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    video_line_buf_if #(.DATA_W(16)) vif ();

    video_line_buf #(
        .DATA_W     (16),
        .WORDS      (128),
        .LINES      (256),
        .LINE_END_W (4)
    ) dut (
        .i_clk     (clk),
        .i_reset_n (reset_n),
        .bus       (vif)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic fill(input logic [15:0] base, input int n, input bit do_reset);
        if (do_reset) begin
            vif.i_vdata_reset = 1'b1;
            tick();
            vif.i_vdata_reset = 1'b0;
        end
        for (int i = 0; i < n; i++) begin
            vif.i_vdata       = base + 16'(i);
            vif.i_vdata_valid = 1'b1;
            tick();
        end
        vif.i_vdata_valid = 1'b0;
    endtask

    task automatic pulse_line();
        vif.i_line_start = 1'b1;
        tick();
        vif.i_line_start = 1'b0;
    endtask

    task automatic read_chk(input string tag, input logic [15:0] exp);
        vif.i_rd_en = 1'b1;
        tick();
        vif.i_rd_en = 1'b0;
        chk(tag, 32'(vif.o_rd_data), 32'(exp));
    endtask

    initial begin
        logic [4:0] le_hist;
        logic       le_any;

        vif.i_vdata       = '0;
        vif.i_vdata_valid = 1'b0;
        vif.i_vdata_reset = 1'b0;
        vif.i_frame_start = 1'b0;
        vif.i_line_start  = 1'b0;
        vif.i_rd_en       = 1'b0;
        tick(3);
        chk("rst_line_idx", 32'(vif.o_line_idx), 32'd0);
        chk("rst_line_end", 32'(vif.o_line_end), 32'd0);
        chk("rst_rd_data",  32'(vif.o_rd_data),  32'd0);
        chk("rst_rd_valid", 32'(vif.o_rd_valid), 32'd0);
        chk("rst_underrun", 32'(vif.o_underrun), 32'd0);
        reset_n = 1'b1;
        tick();

        vif.i_frame_start = 1'b1;
        tick();
        vif.i_frame_start = 1'b0;

`ifdef VIDEO_LINE_BUF_DOUBLE_SCAN_EN
        tick(5);
        fill(16'h4000, 128, 1'b1);
        tick(2);
        pulse_line();
        chk("ds1_line_end", 32'(vif.o_line_end), 32'd1);
        chk("ds1_line_idx", 32'(vif.o_line_idx), 32'd1);
        read_chk("ds1_rd0", 16'h4000);
        read_chk("ds1_rd1", 16'h4001);
        tick(5);
        pulse_line();
        chk("ds2_line_end", 32'(vif.o_line_end), 32'd0);
        read_chk("ds2_rd0", 16'h4000);
        read_chk("ds2_rd1", 16'h4001);
        chk("ds2_underrun", 32'(vif.o_underrun), 32'd0);
        fill(16'h5000, 128, 1'b1);
        tick(2);
        pulse_line();
        chk("ds3_line_end", 32'(vif.o_line_end), 32'd1);
        chk("ds3_line_idx", 32'(vif.o_line_idx), 32'd2);
        read_chk("ds3_rd0", 16'h5000);
        read_chk("ds3_rd1", 16'h5001);
        tick(5);
        pulse_line();
        chk("ds4_line_end", 32'(vif.o_line_end), 32'd0);
        read_chk("ds4_rd0", 16'h5000);
        chk("ds4_underrun", 32'(vif.o_underrun), 32'd0);
`else
        // o_line_end sampled over five cycles: high for exactly four.
        for (int k = 0; k < 5; k++) begin
            le_hist[4-k] = vif.o_line_end;
            tick();
        end
        chk("frame_line_end_width", 32'(le_hist), 32'b11110);
        chk("frame_line_idx", 32'(vif.o_line_idx), 32'd0);

        // 130 words offered; the last two must be dropped.
        fill(16'h0000, 130, 1'b1);
        tick(2);
        chk("fill_state_done", 32'(dut.r_state), 32'(F_DONE));

        pulse_line();
        chk("swap_line_end", 32'(vif.o_line_end), 32'd1);
        chk("swap_line_idx", 32'(vif.o_line_idx), 32'd1);
        for (int i = 0; i < 128; i++)
            read_chk($sformatf("rd_line0_w%0d", i), 16'(i));
        read_chk("rd_over_read", 16'h0000);
        chk("rd_over_valid", 32'(vif.o_rd_valid), 32'd1);
        tick();
        chk("rd_idle_valid", 32'(vif.o_rd_valid), 32'd0);

        fill(16'h1000, 40, 1'b1);
        pulse_line();
        chk("under_flag",     32'(vif.o_underrun), 32'd1);
        chk("under_line_end", 32'(vif.o_line_end), 32'd0);
        chk("under_line_idx", 32'(vif.o_line_idx), 32'd1);
        for (int i = 0; i < 4; i++)
            read_chk($sformatf("under_reread_w%0d", i), 16'(i));
        fill(16'h1028, 88, 1'b0);
        tick(2);
        pulse_line();
        chk("after_under_line_end", 32'(vif.o_line_end), 32'd1);
        chk("after_under_line_idx", 32'(vif.o_line_idx), 32'd3);
        chk("under_sticky",         32'(vif.o_underrun), 32'd1);
        for (int i = 0; i < 42; i++)
            read_chk($sformatf("rd_line1_w%0d", i), 16'h1000 + 16'(i));

        // Frame start and line start together: frame wins, no swap, no re-arm.
        vif.i_frame_start = 1'b1;
        vif.i_line_start  = 1'b1;
        tick();
        vif.i_frame_start = 1'b0;
        vif.i_line_start  = 1'b0;
        chk("simul_underrun", 32'(vif.o_underrun), 32'd0);
        chk("simul_line_idx", 32'(vif.o_line_idx), 32'd0);
        chk("simul_line_end", 32'(vif.o_line_end), 32'd1);
        read_chk("simul_no_swap", 16'h102A);

        // Walk line_cnt to 254 with starved line starts, then feed the last two lines.
        tick(5);
        for (int k = 0; k < 254; k++) begin
            pulse_line();
            tick();
        end
        fill(16'h2000, 128, 1'b1);
        tick(2);
        pulse_line();
        chk("line255_line_idx", 32'(vif.o_line_idx), 32'hFF);
        chk("line255_line_end", 32'(vif.o_line_end), 32'd1);
        chk("line255_underrun", 32'(vif.o_underrun), 32'd1);
        tick(5);
        fill(16'h3000, 128, 1'b1);
        tick(2);
        pulse_line();
        le_any = 1'b0;
        for (int k = 0; k < 6; k++) begin
            le_any |= vif.o_line_end;
            tick();
        end
        chk("last_no_fetch",     32'(le_any),         32'd0);
        chk("last_line_idx",     32'(vif.o_line_idx), 32'hFF);
        read_chk("last_rd_w0",   16'h3000);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
